// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch (IF)
// and data memory (DM) requesters. DM normally has priority; a starvation counter makes sure IF is eventually served.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_wdata,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   starve_cnt_r;
  logic            kill_r;
  logic            served_if_r;
  logic            mem_req_r;
  logic            we_r;
  logic [29:0]     addr_r;
  logic [3:0]      be_r;
  logic [31:0]     wdata_r;
  logic [31:0]     if_rdata_r;
  logic [31:0]     dm_rdata_r;
  logic            if_grantable_s;
  logic            starve_max_s;
  logic            grant_dm_s;
  logic            grant_if_s;
  logic            unused_s;

  // The two low address bits select a byte lane and are not needed for a word address.
  assign unused_s = ^{if_addr[1:0], dm_addr[1:0]};

  assign if_grantable_s = if_req & ~if_flush;
  assign starve_max_s   = (starve_cnt_r == CW'(STARVE_MAX));
  assign grant_dm_s     = (state_r == IDLE) & dm_req & ~(if_grantable_s & starve_max_s);
  assign grant_if_s     = (state_r == IDLE) & if_grantable_s & ~grant_dm_s;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_dm_s) begin
          state_nxt_s = SERVE_DM;
        end else if (grant_if_s) begin
          state_nxt_s = SERVE_IF;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_IF, SERVE_DM: begin
        if (mem_ready) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the granted request; the memory port only ever sees these copies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r      <= 30'd0;
      we_r        <= 1'b0;
      be_r        <= 4'd0;
      wdata_r     <= 32'd0;
      served_if_r <= 1'b0;
      mem_req_r   <= 1'b0;
    end else if (grant_dm_s) begin
      addr_r      <= dm_addr[31:2];
      we_r        <= dm_we;
      be_r        <= dm_be;
      wdata_r     <= dm_wdata;
      served_if_r <= 1'b0;
      mem_req_r   <= 1'b1;
    end else if (grant_if_s) begin
      addr_r      <= if_addr[31:2];
      we_r        <= 1'b0;
      be_r        <= 4'hF;
      wdata_r     <= 32'd0;
      served_if_r <= 1'b1;
      mem_req_r   <= 1'b1;
    end else if (mem_req_r && mem_ready) begin
      mem_req_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_r;
    end
  end

  // Count DM grants that overtake a waiting fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= '0;
    end else if (!if_req || grant_if_s) begin
      starve_cnt_r <= '0;
    end else if (grant_dm_s && !starve_max_s) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // A flush during a fetch lets the memory cycle finish but discards its result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_r <= 1'b0;
    end else if (state_r == SERVE_IF && if_flush) begin
      kill_r <= 1'b1;
    end else if (state_r == DONE) begin
      kill_r <= 1'b0;
    end else begin
      kill_r <= kill_r;
    end
  end

  // Capture read data on the completing edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_r <= 32'd0;
      dm_rdata_r <= 32'd0;
    end else begin
      if (state_r == SERVE_IF && mem_ready && !kill_r && !if_flush) begin
        if_rdata_r <= mem_rdata;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (state_r == SERVE_DM && mem_ready && !we_r) begin
        dm_rdata_r <= mem_rdata;
      end else begin
        dm_rdata_r <= dm_rdata_r;
      end
    end
  end

  assign if_rvalid = (state_r == DONE) & served_if_r & ~kill_r & ~if_flush;
  assign dm_rvalid = (state_r == DONE) & ~served_if_r;
  assign if_stall  = if_req & ~if_rvalid;
  assign dm_stall  = dm_req & ~dm_rvalid;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_be    = be_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a table of single accesses plus
// hand-written sequences for contention, flush, reset and wait states.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_rvalid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_rvalid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_ready;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  unified_mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic [29:0] exp_maddr;
    logic [3:0]  exp_be;
    bit          exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access from IDLE; returns at posedge+1 with the FSM in IDLE.
  task automatic run_vec(input vec_t v);
    mem_ready = 1'b0;
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_be = v.be; dm_wdata = v.wdata;
    end
    @(negedge clk);
    check("vec_idle_stall", v.is_if ? if_stall : dm_stall, 32'd1);
    check("vec_idle_mem_req", mem_req, 32'd0);
    tick();
    @(negedge clk);
    check("vec_mem_req", mem_req, 32'd1);
    check("vec_mem_addr", mem_addr, {2'b00, v.exp_maddr});
    check("vec_mem_be", mem_be, {28'd0, v.exp_be});
    check("vec_mem_we", mem_we, {31'd0, v.exp_we});
    if (!v.is_if) check("vec_mem_wdata", mem_wdata, v.wdata);
    repeat (v.delay) tick();
    mem_ready = 1'b1;
    mem_rdata = v.mrdata;
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("vec_done_mem_req", mem_req, 32'd0);
    check("vec_rvalid", v.is_if ? if_rvalid : dm_rvalid, 32'd1);
    check("vec_other_rvalid", v.is_if ? dm_rvalid : if_rvalid, 32'd0);
    check("vec_done_stall", v.is_if ? if_stall : dm_stall, 32'd0);
    check("vec_rdata", v.is_if ? if_rdata : dm_rdata, v.exp_rdata);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    @(negedge clk);
    check("vec_rvalid_pulse", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    //            is_if we addr           be     wdata          mrdata        dly maddr          be     we exp_rdata
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hCAFE_0001, 0, 30'h4,        4'hF, 1'b0, 32'hCAFE_0001};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0021, 4'h2, 32'h0000_AB00, 32'hDEAD_0000, 0, 30'h8,        4'h2, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h1000_0007, 4'hF, 32'h0,        32'h1234_5678, 2, 30'h0400_0001, 4'hF, 1'b0, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 4'h9, 32'h1122_3344, 32'hFFFF_0000, 1, 30'h3FFF_FFFF, 4'h9, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0,        32'h0BAD_F00D, 3, 30'h3FFF_FFFF, 4'hF, 1'b0, 32'h0BAD_F00D};

    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_be = 4'd0; dm_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    #12;
    check("rst_mem_req", mem_req, 32'd0);
    check("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_mem_fields", {mem_addr, mem_we, mem_be[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Continuous contention: four DM grants, then one IF grant, repeating
    if_addr = 32'h0000_0100; dm_addr = 32'h0000_0200; dm_we = 1'b0; dm_be = 4'hF;
    mem_rdata = 32'hC0C0_C0C0; mem_ready = 1'b1;
    if_req = 1'b1; dm_req = 1'b1;
    g = 0;
    for (int c = 0; c < 80 && g < 10; c++) begin
      @(negedge clk);
      if (mem_req) begin
        check("contention_grant", mem_addr, (g % 5 == 4) ? 32'h40 : 32'h80);
        g++;
      end
    end
    check("contention_count", g, 32'd10);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b0;

    // Flush in the second SERVE_IF cycle with three wait cycles
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h5555_5555;
    tick();
    @(negedge clk); check("flush_serve1", mem_req, 32'd1);
    tick(); if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk); check("flush_serve2", mem_req, 32'd1);
    tick(); if_flush = 1'b0;
    @(negedge clk); check("flush_serve3", mem_req, 32'd1);
    tick(); mem_ready = 1'b1;
    @(negedge clk); check("flush_serve4", mem_req, 32'd1);
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    check("flush_done_mem_req", mem_req, 32'd0);
    check("flush_no_rvalid", if_rvalid, 32'd0);
    check("flush_if_rdata", if_rdata, 32'hC0C0_C0C0);
    tick();
    @(negedge clk);
    check("flush_idle", {30'd0, mem_req, if_rvalid}, 32'd0);
    tick();

    // Flush in IDLE holds the fetch back for exactly one cycle
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h0000_0080;
    @(negedge clk); check("idle_flush_c0", mem_req, 32'd0);
    tick(); if_flush = 1'b0;
    @(negedge clk); check("idle_flush_blocked", mem_req, 32'd0);
    tick();
    @(negedge clk);
    check("idle_flush_grant", mem_req, 32'd1);
    check("idle_flush_addr", mem_addr, 32'h20);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    check("idle_flush_rvalid", if_rvalid, 32'd1);
    check("idle_flush_rdata", if_rdata, 32'h0000_0077);
    if_req = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a DM access
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; dm_be = 4'hF;
    mem_rdata = 32'h0000_0099;
    tick();
    @(negedge clk); check("rst_mid_serve", mem_req, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 32'd0);
    check("rst_mid_dm_rvalid", dm_rvalid, 32'd0);
    check("rst_mid_if_rdata", if_rdata, 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_hold_rvalid", {30'd0, dm_rvalid, mem_req}, 32'd0);
    end
    rst = 1'b1; mem_ready = 1'b0;
    tick();
    @(negedge clk);
    check("rst_regrant", mem_req, 32'd1);
    check("rst_regrant_addr", mem_addr, 32'hC0);
    mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    check("rst_regrant_rvalid", dm_rvalid, 32'd1);
    check("rst_regrant_rdata", dm_rdata, 32'h0000_0099);
    dm_req = 1'b0;
    repeat (2) tick();

    // Five wait states with DM fields changing during the access
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0044; dm_be = 4'hC; dm_wdata = 32'hA5A5_A5A5;
    tick();
    dm_addr = 32'h0000_0888; dm_wdata = 32'd0; dm_be = 4'h1; dm_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("ws_mem_addr", mem_addr, 32'h11);
      check("ws_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("ws_mem_we_be", {mem_we, mem_be}, 32'h1C);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("ws_ready_cycle_rvalid", dm_rvalid, 32'd0);
    check("ws_ready_cycle_req", mem_req, 32'd1);
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    check("ws_rvalid", dm_rvalid, 32'd1);
    check("ws_dm_rdata", dm_rdata, 32'h0000_0099);
    check("ws_done_mem_req", mem_req, 32'd0);
    dm_req = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
